reduction_accumulator: RTL and testbench
========================================

REDUCTION_ACCUMULATOR -- requirements
Module: reduction_accumulator

Interface
REQ-001 SHALL have parameter ValidBitPos, default 81, flit valid-bit index; FlitWidth = ValidBitPos+1.
REQ-002 SHALL have parameter lg_numprocs, default 3, children-field width; FlitChildWidth = FlitWidth+lg_numprocs (85).
REQ-003 SHALL have parameter FAN_IN, default 6, number of router ports.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in  input  FlitChildWidth  flit from the upstream port selector.
REQ-007 in_valid  input  1  in holds a flit.
REQ-008 in_port  input  3  index of the port that supplied in (0..FAN_IN-1).
REQ-009 in_ready  output  1  flit accepted this cycle when in_valid&&in_ready; upstream pops the selected port queue on this.
REQ-010 out  output  FlitChildWidth  reduced result flit.
REQ-011 out_valid  output  1  out holds a result.
REQ-012 out_ready  input  1  downstream accepts out.
REQ-013 contrib_mask  output  FAN_IN  ports that contributed to the current or emitted reduction.
REQ-014 dup_err  output  1  one-cycle pulse: a duplicate-port flit was dropped.

Function
REQ-015 Field map: children count in[FlitChildWidth-1:FlitWidth]; valid bit in[ValidBitPos]; op code in[80:79]; header in[80:32]; data in[31:0].
REQ-016 Op codes SHALL be 00 unsigned sum mod 2^32, 01 unsigned max, 10 unsigned min, 11 bitwise OR.
REQ-017 Expected contributions SHALL be the children field of the first flit, with 0 treated as 1.
REQ-018 States SHALL be IDLE, ACCUM, EMIT.
REQ-019 IDLE: in_ready=1; an accepted flit loads acc=data, header, expected, count=1, contrib_mask=1<<in_port, then goes to EMIT if expected==1, else ACCUM.
REQ-020 ACCUM: in_ready=1; an accepted flit from a port not in contrib_mask does acc=op(acc,data), count+1, sets the mask bit, and goes to EMIT when count+1==expected.
REQ-021 ACCUM: an accepted flit from a port already in contrib_mask SHALL be consumed, not combined, and SHALL pulse dup_err the next cycle; state and count are unchanged.
REQ-022 Op and header of the first flit SHALL govern the whole reduction; later flit op/header fields are ignored.
REQ-023 EMIT: in_ready=0; out_valid=1; out = {count[lg_numprocs-1:0], 1'b1 at ValidBitPos, header, acc}.
REQ-024 EMIT: out and out_valid SHALL hold stable until out_ready; on out_valid&&out_ready go to IDLE with contrib_mask cleared.
REQ-025 Latency: the final contributing flit accepted in cycle N SHALL give out_valid=1 in cycle N+1 (registered output, no combinational in->out path).
REQ-026 in_ready SHALL depend only on state, never combinationally on out_ready.
REQ-027 Flits with in[ValidBitPos]=0 SHALL be accepted and ignored in all states that accept input.
REQ-028 in_port >= FAN_IN SHALL be treated as a duplicate (dropped, dup_err pulse).

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, out_valid=0, out=0, contrib_mask=0, dup_err=0, acc=0, count=0, from any state including mid-ACCUM and mid-EMIT; in_ready=1 the following cycle.
REQ-030 While rst=1, in_ready=0 and no flit is consumed.

Structure
REQ-031 Field bit positions, op-code values and state encodings SHALL be defined in a shared package, reduction_pkg, for use with the selector and router stages.
REQ-032 The combine operation SHALL be a combinational sub-module, reduction_alu (op, a, b -> 32-bit result).

Verification
REQ-033 Sum: first flit children=3, op=00, data 5 (port 0), then 7 (port 2), then 0xFFFFFFFF (port 4) -> out data 0x0000000B, children field 3, contrib_mask 010101b, out_valid one cycle after the third accept.
REQ-034 Max/min: children=2, op=01, data 9 then 3 -> 9; repeat with op=10 -> 3.
REQ-035 Duplicate: children=2, port 1 data 4, port 1 data 6, port 3 data 1 with op=00 -> dup_err pulse after the second flit, result 5.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles in EMIT with in_valid=1 -> out stable, in_ready=0, no flit consumed; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-ACCUM: after 1 of 3 contributions assert rst -> all outputs 0; a new single-child flit (children=0, data 0x2A) -> out data 0x2A next cycle.
REQ-038 Single child: children=1, op=11, data 0xF0 -> EMIT directly, out data 0xF0, contrib_mask one-hot.

Source files
------------

// File: rtl/reduction_pkg.sv
// Shared field layout, op codes and state encodings for the reduction datapath
// (used by the selector, router and accumulator stages).
package reduction_pkg;

    localparam int DATA_W = 32;
    localparam int HDR_LO = 32;
    localparam int OP_W   = 2;
    localparam int PORT_W = 3;

    typedef enum logic [1:0] {
        OP_SUM = 2'b00,
        OP_MAX = 2'b01,
        OP_MIN = 2'b10,
        OP_OR  = 2'b11
    } red_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_EMIT  = 2'b10
    } red_state_e;

endpackage

// File: rtl/reduction_alu.sv
// Combinational combine step of a reduction: result = op(a, b) on 32-bit unsigned data.
module reduction_alu
    import reduction_pkg::*;
(
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = a_i + b_i;
        case (red_op_e'(op_i))
            OP_SUM:  result_o = a_i + b_i;
            OP_MAX:  result_o = (a_i >= b_i) ? a_i : b_i;
            OP_MIN:  result_o = (a_i <= b_i) ? a_i : b_i;
            OP_OR:   result_o = a_i | b_i;
            default: result_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/reduction_accumulator.sv
// Collects one flit per distinct port, folds their data with the first flit's op,
// and emits a single result flit held until the downstream accepts it.
module reduction_accumulator
    import reduction_pkg::*;
#(
    parameter int ValidBitPos = 81,
    parameter int lg_numprocs = 3,
    parameter int FAN_IN      = 6,
    localparam int FlitWidth      = ValidBitPos + 1,
    localparam int FlitChildWidth = FlitWidth + lg_numprocs
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FlitChildWidth-1:0] in,
    input  logic                      in_valid,
    input  logic [PORT_W-1:0]         in_port,
    output logic                      in_ready,
    output logic [FlitChildWidth-1:0] out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FAN_IN-1:0]         contrib_mask,
    output logic                      dup_err
);

    localparam int HdrW = ValidBitPos - HDR_LO;
    localparam int CntW = lg_numprocs + 1;

    red_state_e                state_q;
    logic [DATA_W-1:0]         acc_q;
    logic [HdrW-1:0]           hdr_q;
    logic [CntW-1:0]           count_q;
    logic [CntW-1:0]           expected_q;
    logic [FAN_IN-1:0]         mask_q;
    logic                      dup_q;
    logic                      out_valid_q;
    logic [FlitChildWidth-1:0] out_q;

    logic [lg_numprocs-1:0] in_children;
    logic                   in_flit_valid;
    logic [HdrW-1:0]        in_hdr;
    logic [DATA_W-1:0]      in_data;
    logic [FAN_IN-1:0]      port_onehot;
    logic                   port_ok;
    logic                   is_dup;
    logic                   accept;
    logic [CntW-1:0]        first_expected;
    logic [CntW-1:0]        count_inc;
    logic [DATA_W-1:0]      alu_res;

    assign in_children   = in[FlitChildWidth-1:FlitWidth];
    assign in_flit_valid = in[ValidBitPos];
    assign in_hdr        = in[ValidBitPos-1:HDR_LO];
    assign in_data       = in[DATA_W-1:0];

    generate
        for (genvar gi = 0; gi < FAN_IN; gi++) begin : g_port_dec
            assign port_onehot[gi] = (in_port == PORT_W'(gi));
        end
    endgenerate

    // Out-of-range ports decode to no bit and are rejected like duplicates.
    assign port_ok        = |port_onehot;
    assign is_dup         = ~port_ok | (|(port_onehot & mask_q));
    assign in_ready       = ~rst & (state_q != ST_EMIT);
    assign accept         = in_valid & in_ready;
    assign first_expected = (in_children == '0) ? CntW'(1) : {1'b0, in_children};
    assign count_inc      = count_q + CntW'(1);

    reduction_alu u_alu (
        .op_i     (hdr_q[HdrW-1 -: OP_W]),
        .a_i      (acc_q),
        .b_i      (in_data),
        .result_o (alu_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            hdr_q       <= '0;
            count_q     <= '0;
            expected_q  <= '0;
            mask_q      <= '0;
            dup_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            dup_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && in_flit_valid) begin
                        if (!port_ok) begin
                            dup_q <= 1'b1;
                        end else begin
                            acc_q      <= in_data;
                            hdr_q      <= in_hdr;
                            expected_q <= first_expected;
                            count_q    <= CntW'(1);
                            mask_q     <= port_onehot;
                            if (first_expected == CntW'(1)) begin
                                state_q     <= ST_EMIT;
                                out_valid_q <= 1'b1;
                                out_q       <= {lg_numprocs'(1), 1'b1, in_hdr, in_data};
                            end else begin
                                state_q <= ST_ACCUM;
                            end
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept && in_flit_valid) begin
                        if (is_dup) begin
                            dup_q <= 1'b1;
                        end else begin
                            acc_q   <= alu_res;
                            count_q <= count_inc;
                            mask_q  <= mask_q | port_onehot;
                            if (count_inc == expected_q) begin
                                state_q     <= ST_EMIT;
                                out_valid_q <= 1'b1;
                                out_q       <= {count_inc[lg_numprocs-1:0], 1'b1, hdr_q, alu_res};
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_q       <= '0;
                        mask_q      <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out          = out_q;
    assign out_valid    = out_valid_q;
    assign contrib_mask = mask_q;
    assign dup_err      = dup_q;

endmodule

// File: tb/tb_reduction_accumulator.sv
// Directed bench for reduction_accumulator: sum, max/min, duplicates, backpressure,
// mid-reduction reset and single-child reductions against hand-computed results.
module tb_reduction_accumulator;

    localparam logic [46:0] HDR_FILL = 47'h1234;

    logic        clk = 1'b0;
    logic        rst;
    logic [84:0] in;
    logic        in_valid;
    logic [2:0]  in_port;
    logic        in_ready;
    logic [84:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  contrib_mask;
    logic        dup_err;

    int checks   = 0;
    int failures = 0;

    reduction_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .in_valid     (in_valid),
        .in_port      (in_port),
        .in_ready     (in_ready),
        .out          (out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .contrib_mask (contrib_mask),
        .dup_err      (dup_err)
    );

    always #5 clk = ~clk;

    function automatic logic [84:0] mk(input logic [2:0] ch, input logic v,
                                       input logic [1:0] op, input logic [31:0] d);
        return {ch, v, op, HDR_FILL, d};
    endfunction

    function automatic logic [84:0] res(input logic [2:0] cnt, input logic [1:0] op,
                                        input logic [31:0] d);
        return {cnt, 1'b1, op, HDR_FILL, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one flit for one cycle; it must be accepted.
    task automatic send(input logic [84:0] f, input logic [2:0] p);
        in       = f;
        in_port  = p;
        in_valid = 1'b1;
        chk("send_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        $display("tb: sent port=%0d flit=%0h out_valid=%0b dup_err=%0b mask=%b",
                 p, f, out_valid, dup_err, contrib_mask);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_out_valid", 128'(out_valid), 128'(0));
        chk("drain_mask", 128'(contrib_mask), 128'(0));
        chk("drain_in_ready", 128'(in_ready), 128'(1));
    endtask

    initial begin
        rst       = 1'b1;
        in        = '0;
        in_valid  = 1'b0;
        in_port   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out", 128'(out), 128'(0));
        chk("rst_mask", 128'(contrib_mask), 128'(0));
        chk("rst_dup", 128'(dup_err), 128'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Sum of three with wraparound: 5 + 7 + 0xFFFFFFFF = 0xB
        send(mk(3'd3, 1'b1, 2'b00, 32'd5), 3'd0);
        chk("sum_mask1", 128'(contrib_mask), 128'(6'b000001));
        chk("sum_nv1", 128'(out_valid), 128'(0));
        send(mk(3'd3, 1'b1, 2'b00, 32'd7), 3'd2);
        chk("sum_nv2", 128'(out_valid), 128'(0));
        send(mk(3'd3, 1'b1, 2'b00, 32'hFFFF_FFFF), 3'd4);
        chk("sum_valid", 128'(out_valid), 128'(1));
        chk("sum_out", 128'(out), 128'(res(3'd3, 2'b00, 32'h0000_000B)));
        chk("sum_mask", 128'(contrib_mask), 128'(6'b010101));
        chk("sum_in_ready", 128'(in_ready), 128'(0));
        drain();

        // Max of 9, 3
        send(mk(3'd2, 1'b1, 2'b01, 32'd9), 3'd0);
        send(mk(3'd2, 1'b1, 2'b01, 32'd3), 3'd1);
        chk("max_out", 128'(out), 128'(res(3'd2, 2'b01, 32'd9)));
        drain();

        // Min of 9, 3; second flit carries a different op which must be ignored
        send(mk(3'd2, 1'b1, 2'b10, 32'd9), 3'd0);
        send(mk(3'd2, 1'b1, 2'b01, 32'd3), 3'd1);
        chk("min_out", 128'(out), 128'(res(3'd2, 2'b10, 32'd3)));
        drain();

        // Duplicate port, invalid-bit flit and out-of-range port inside one reduction
        send(mk(3'd2, 1'b1, 2'b00, 32'd4), 3'd1);
        send(mk(3'd2, 1'b1, 2'b00, 32'd6), 3'd1);
        chk("dup_pulse", 128'(dup_err), 128'(1));
        chk("dup_no_emit", 128'(out_valid), 128'(0));
        chk("dup_mask", 128'(contrib_mask), 128'(6'b000010));
        send(mk(3'd2, 1'b0, 2'b00, 32'd100), 3'd5);
        chk("novalid_no_dup", 128'(dup_err), 128'(0));
        chk("novalid_mask", 128'(contrib_mask), 128'(6'b000010));
        send(mk(3'd2, 1'b1, 2'b00, 32'd50), 3'd7);
        chk("badport_dup", 128'(dup_err), 128'(1));
        chk("badport_mask", 128'(contrib_mask), 128'(6'b000010));
        send(mk(3'd2, 1'b1, 2'b00, 32'd1), 3'd3);
        chk("dup_clear", 128'(dup_err), 128'(0));
        chk("dup_out", 128'(out), 128'(res(3'd2, 2'b00, 32'd5)));
        chk("dup_mask_final", 128'(contrib_mask), 128'(6'b001010));

        drain();

        // Single child straight to EMIT, then hold under backpressure with in_valid=1
        send(mk(3'd1, 1'b1, 2'b11, 32'hF0), 3'd2);
        chk("single_valid", 128'(out_valid), 128'(1));
        chk("single_out", 128'(out), 128'(res(3'd1, 2'b11, 32'hF0)));
        chk("single_mask", 128'(contrib_mask), 128'(6'b000100));
        in       = mk(3'd1, 1'b1, 2'b00, 32'h77);
        in_port  = 3'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out", 128'(out), 128'(res(3'd1, 2'b11, 32'hF0)));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_mask", 128'(contrib_mask), 128'(6'b000100));
        end
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a three-way reduction
        send(mk(3'd3, 1'b1, 2'b00, 32'd1), 3'd0);
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out", 128'(out), 128'(0));
        chk("midrst_mask", 128'(contrib_mask), 128'(0));
        chk("midrst_dup", 128'(dup_err), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready", 128'(in_ready), 128'(1));
        send(mk(3'd0, 1'b1, 2'b00, 32'h2A), 3'd5);
        chk("zero_child_valid", 128'(out_valid), 128'(1));
        chk("zero_child_out", 128'(out), 128'(res(3'd1, 2'b00, 32'h2A)));
        chk("zero_child_mask", 128'(contrib_mask), 128'(6'b100000));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
